// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared phase-state encodings and direction constants for quad_decoder
//
// Contents:
//   quad_state_t   filtered {A,B} phase pair, named in forward (up) order
//   DIR_UP/DOWN    values driven on up_down
//   quad_fwd_next  forward successor of a phase state (00->01->11->10->00)
package quad_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic quad_state_t quad_fwd_next(input quad_state_t s);
    case (s)
      QS_00:   quad_fwd_next = QS_01;
      QS_01:   quad_fwd_next = QS_11;
      QS_11:   quad_fwd_next = QS_10;
      default: quad_fwd_next = QS_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - synchronizer plus glitch filter for one asynchronous pin
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset; clears chain, counter and output
//   pin       in   asynchronous input pin
//   filtered  out  pin value after SYNC_STAGES flops and FILTER_LEN-sample agreement
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filtered
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt_q counts consecutive synced samples that disagree with the filtered
  // value; any agreeing sample restarts the count, so short pulses vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filtered <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (synced == filtered) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filtered <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder producing step/direction and a position count
//
// Optional feature: define QUAD_INDEX_EN to add the index pin, which zeroes
// position on its filtered rising edge.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   index     in   index pin, asynchronous (QUAD_INDEX_EN only)
//   quad_a    in   phase A pin, asynchronous
//   quad_b    in   phase B pin, asynchronous
//   clear     in   synchronous position clear
//   err_clr   in   clears the sticky error flag
//   step      out  one-cycle pulse per legal quadrature edge
//   up_down   out  direction of last step, 0 = up, 1 = down
//   position  out  running count, wraps modulo 2^WIDTH
//   error     out  sticky illegal-transition flag
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
`ifdef QUAD_INDEX_EN
  input  logic             index,
`endif
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] position,
  output logic             error
);

  logic        a_f;
  logic        b_f;
  logic        idx_rise;
  quad_state_t cur_st;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk      (clk),
    .reset    (reset),
    .pin      (quad_a),
    .filtered (a_f)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk      (clk),
    .reset    (reset),
    .pin      (quad_b),
    .filtered (b_f)
  );

`ifdef QUAD_INDEX_EN
  logic idx_f;
  logic idx_q;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_idx (
    .clk      (clk),
    .reset    (reset),
    .pin      (index),
    .filtered (idx_f)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 1'b0;
    end else begin
      idx_q <= idx_f;
    end
  end

  assign idx_rise = idx_f & ~idx_q;
`else
  assign idx_rise = 1'b0;
`endif

  assign cur_st = quad_state_t'({a_f, b_f});

  quad_state_t      prev_q, prev_n;
  logic             primed_q, primed_n;
  logic             step_q, step_n;
  logic             dir_q, dir_n;
  logic             err_q, err_n;
  logic [WIDTH-1:0] pos_q, pos_n;
  logic             fwd, rev, bad;

  // Transition classification; nothing is decoded until the previous state
  // has been loaded once after reset.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    if (primed_q && (cur_st != prev_q)) begin
      if (cur_st == quad_fwd_next(prev_q)) begin
        fwd = 1'b1;
      end else if (prev_q == quad_fwd_next(cur_st)) begin
        rev = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end
  end

  always_comb begin
    prev_n   = cur_st;
    primed_n = 1'b1;
    step_n   = 1'b0;
    dir_n    = dir_q;
    err_n    = err_q;
    pos_n    = pos_q;

    if (fwd) begin
      step_n = 1'b1;
      dir_n  = DIR_UP;
      pos_n  = pos_q + WIDTH'(1);
    end else if (rev) begin
      step_n = 1'b1;
      dir_n  = DIR_DOWN;
      pos_n  = pos_q - WIDTH'(1);
    end

    // A new illegal transition beats a simultaneous clear request.
    if (bad) begin
      err_n = 1'b1;
    end else if (err_clr) begin
      err_n = 1'b0;
    end

    // Later assignments win: clear over index over step.
    if (idx_rise) begin
      pos_n = '0;
    end
    if (clear) begin
      pos_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= QS_00;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= DIR_UP;
      err_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      prev_q   <= prev_n;
      primed_q <= primed_n;
      step_q   <= step_n;
      dir_q    <= dir_n;
      err_q    <= err_n;
      pos_q    <= pos_n;
    end
  end

  assign step     = step_q;
  assign up_down  = dir_q;
  assign position = pos_q;
  assign error    = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - self-checking bench for quad_decoder against a phase-index model
module tb_quad_decoder;

  localparam int WIDTH = 16;
  localparam int SS    = 2;
  localparam int FL    = 3;
  localparam int LAT   = SS + FL + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             quad_a;
  logic             quad_b;
  logic             clear;
  logic             err_clr;
  logic             step;
  logic             up_down;
  logic [WIDTH-1:0] position;
  logic             error;
`ifdef QUAD_INDEX_EN
  logic             index;
`endif

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef QUAD_INDEX_EN
    .index    (index),
`endif
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .clear    (clear),
    .err_clr  (err_clr),
    .step     (step),
    .up_down  (up_down),
    .position (position),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the encoder is a point on a 4-position ring; pins are the Gray
  // code of that point, position is an integer mod 2^16.
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_ph, m_pos, m_dir, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_step);
    chk({tag, ".step"}, step, exp_step);
    chk({tag, ".position"}, position, m_pos);
    chk({tag, ".up_down"}, up_down, m_dir);
    chk({tag, ".error"}, error, m_err);
  endtask

  // delta: +1 forward, -1 reverse, 2 illegal jump. Optional clear / err_clr
  // are presented exactly on the edge that produces the step.
  task automatic do_edge(input int delta, input int hold, input bit clr_lat, input bit eclr_lat);
    bit legal;
    legal = (delta != 2);
    m_ph = (m_ph + delta + 4) % 4;
    {quad_a, quad_b} = seq[m_ph];
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (k == LAT) begin
        if (legal) begin
          if (clr_lat) m_pos = 0;
          else m_pos = (m_pos + ((delta == 1) ? 1 : 65535)) % 65536;
          m_dir = (delta == 1) ? 0 : 1;
        end else begin
          m_err = 1;
        end
        clear   = 1'b0;
        err_clr = 1'b0;
      end
      chk_all("edge", (k == LAT) && legal);
      if (k == LAT - 1) begin
        clear   = clr_lat;
        err_clr = eclr_lat;
      end
    end
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = 0;
    chk("clear_pulse", position, 0);
  endtask

  task automatic err_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 0;
    chk("err_clr_pulse", error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0; clear = 1'b0; err_clr = 1'b0;
`ifdef QUAD_INDEX_EN
    index = 1'b0;
`endif
    m_ph = 0; m_pos = 0; m_dir = 0; m_err = 0;
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_all("idle", 1'b0);
    end

    for (int i = 0; i < 4; i++) do_edge(1, 10, 1'b0, 1'b0);
    chk("fwd4_position", position, 4);
    chk("fwd4_dir", up_down, 0);

    clear_pulse();
    do_edge(-1, 10, 1'b0, 1'b0);
    chk("wrap_down", position, 32'hFFFF);
    chk("wrap_down_dir", up_down, 1);
    do_edge(1, 10, 1'b0, 1'b0);
    chk("wrap_up", position, 0);

    // 2-cycle glitch on A must be swallowed by the filter.
    quad_a = ~quad_a;
    @(negedge clk); chk_all("glitch", 1'b0);
    @(negedge clk); chk_all("glitch", 1'b0);
    quad_a = ~quad_a;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_all("glitch", 1'b0);
    end

    do_edge(2, 10, 1'b0, 1'b0);
    chk("illegal_error", error, 1);
    err_pulse();
    do_edge(2, 10, 1'b0, 1'b1);
    chk("set_beats_clr", error, 1);
    err_pulse();

    clear_pulse();
    for (int i = 0; i < 7; i++) do_edge(1, 8, 1'b0, 1'b0);
    chk("pos7", position, 7);
    do_edge(1, 10, 1'b1, 1'b0);
    chk("clear_with_step", position, 0);

`ifdef QUAD_INDEX_EN
    for (int i = 0; i < 5; i++) do_edge(1, 8, 1'b0, 1'b0);
    chk("pos5", position, 5);
    index = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == LAT) m_pos = 0;
      chk_all("index", 1'b0);
      if (k == 4) index = 1'b0;
    end
`endif

    for (int i = 0; i < 40; i++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      hold = $urandom_range(7, 12);
      if (r < 5) begin
        do_edge(1, hold, ($urandom_range(0, 7) == 0), 1'b0);
      end else if (r < 9) begin
        do_edge(-1, hold, ($urandom_range(0, 7) == 0), 1'b0);
      end else begin
        do_edge(2, hold, 1'b0, 1'b0);
        if ($urandom_range(0, 1) == 1) err_pulse();
      end
    end

    // Reset while a pin change is still inside the filter.
    {quad_a, quad_b} = seq[(m_ph + 1) % 4];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    quad_a = 1'b0;
    quad_b = 1'b0;
    repeat (2) @(negedge clk);
    m_ph = 0; m_pos = 0; m_dir = 0; m_err = 0;
    chk_all("mid_reset", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk_all("post_reset", 1'b0);
    end
    do_edge(1, 10, 1'b0, 1'b0);
    chk("reprime_step", position, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
